ext_mem_responder: RTL

Synthesizable external memory slave. It answers the MainCPU external bus (MemIO, ExternalAddressBus, ExternalDataBus, ExternalExchangeReady) as the memory-side end of that protocol. It serves instruction fetches, data reads and data writes from an internal word array, with programmable wait states. It is placed on the board-level top beside MainCPU and replaces hand-driven bus stimulus in system simulation.

---
 rtl/ext_bus_pkg.sv | 19 +
 rtl/ext_mem_array.sv | 48 ++++
 rtl/ext_mem_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ext_bus_pkg.sv
// Shared encodings for the MainCPU external bus and the memory responder FSM.
// Pure declarations; no logic, no latency.
package ext_bus_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] MEMIO_IDLE  = 2'b00;
   localparam logic [1:0] MEMIO_READ  = 2'b01;
   localparam logic [1:0] MEMIO_WRITE = 2'b10;
   localparam logic [1:0] MEMIO_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      READY   = 2'd2,
      RELEASE = 2'd3
   } memState_t;

endpackage

// File: rtl/ext_mem_array.sv
// DEPTH x 32 single-port synchronous RAM; bus and backdoor share the one port.
// Read data is registered (one edge); no backpressure, the caller never overlaps bus and backdoor.
module ext_mem_array
   import ext_bus_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              busWe,
   input  logic              busRe,
   input  logic              busZero,
   input  logic [ADDR_W-1:0] busIdx,
   input  logic [DATA_W-1:0] busWrData,
   input  logic              loadWe,
   input  logic [ADDR_W-1:0] loadIdx,
   input  logic [DATA_W-1:0] loadData,
   output logic [DATA_W-1:0] rdData
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              we;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] wData;

   always_comb begin
      we    = busWe | loadWe;
      idx   = loadWe ? loadIdx : busIdx;
      wData = loadWe ? loadData : busWrData;
   end

   // The array itself is never reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdData <= '0;
      end else if (busRe) begin
         rdData <= busZero ? '0 : mem[idx];
      end
   end

endmodule

// File: rtl/ext_mem_responder.sv
// Memory-side slave of the MainCPU external bus with programmable wait and ready lengths.
// Ready rises WAIT_CYCLES+1 edges after capture; a held request is served once, then waits for idle.
module ext_mem_responder
   import ext_bus_pkg::*;
#(
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter int unsigned READY_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        MemIO,
   input  logic [31:0]       ExternalAddressBus,
   input  logic [DATA_W-1:0] ExtDataIn,
   output logic [DATA_W-1:0] ExtDataOut,
   output logic              ExtDataOE,
   output logic              ExternalExchangeReady,
   input  logic              LoadEn,
   input  logic [ADDR_W-1:0] LoadAddr,
   input  logic [DATA_W-1:0] LoadData,
   output logic              LoadAck,
   output logic              AddrError
);

   localparam int WCNT_W = $clog2(WAIT_CYCLES + 1) + 1;
   localparam int RCNT_W = $clog2(READY_CYCLES + 1) + 1;

   memState_t         state;
   logic [WCNT_W-1:0] waitCnt;
   logic [RCNT_W-1:0] readyCnt;
   logic [ADDR_W-1:0] addrIdx;
   logic              inRange;
   logic              isWrite;

   logic reqValid;
   logic reqOutOfRange;
   logic readyEntry;
   logic busWe;
   logic busRe;
   logic loadWe;

   always_comb begin
      reqValid      = (MemIO == MEMIO_READ) || (MemIO == MEMIO_WRITE);
      reqOutOfRange = |ExternalAddressBus[31:ADDR_W];
      // First READY edge is the only one where ready is still low.
      readyEntry    = (state == READY) && !ExternalExchangeReady;
      busWe         = readyEntry && isWrite && inRange && !rst;
      busRe         = readyEntry && !isWrite && !rst;
      loadWe        = (state == IDLE) && !reqValid && LoadEn && !rst;
   end

   ext_mem_array #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) uArray (
      .clk      (clk),
      .rst      (rst),
      .busWe    (busWe),
      .busRe    (busRe),
      .busZero  (!inRange),
      .busIdx   (addrIdx),
      .busWrData(ExtDataIn),
      .loadWe   (loadWe),
      .loadIdx  (LoadAddr),
      .loadData (LoadData),
      .rdData   (ExtDataOut)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= IDLE;
         waitCnt               <= '0;
         readyCnt              <= '0;
         addrIdx               <= '0;
         inRange               <= 1'b0;
         isWrite               <= 1'b0;
         ExtDataOE             <= 1'b0;
         ExternalExchangeReady <= 1'b0;
         LoadAck               <= 1'b0;
         AddrError             <= 1'b0;
      end else begin
         LoadAck <= 1'b0;
         case (state)
            IDLE: begin
               if (reqValid) begin
                  addrIdx <= ExternalAddressBus[ADDR_W-1:0];
                  isWrite <= (MemIO == MEMIO_WRITE);
                  inRange <= !reqOutOfRange;
                  if (reqOutOfRange) begin
                     AddrError <= 1'b1;
                  end
                  if (WAIT_CYCLES != 0) begin
                     waitCnt <= WCNT_W'(WAIT_CYCLES);
                     state   <= WAIT;
                  end else begin
                     state <= READY;
                  end
               end else if (LoadEn) begin
                  LoadAck <= 1'b1;
               end
            end
            WAIT: begin
               waitCnt <= waitCnt - WCNT_W'(1);
               if (waitCnt == WCNT_W'(1)) begin
                  state <= READY;
               end
            end
            READY: begin
               if (!ExternalExchangeReady) begin
                  ExternalExchangeReady <= 1'b1;
                  ExtDataOE             <= !isWrite;
                  readyCnt              <= RCNT_W'(1);
               end else if (readyCnt == RCNT_W'(READY_CYCLES)) begin
                  ExternalExchangeReady <= 1'b0;
                  ExtDataOE             <= 1'b0;
                  readyCnt              <= '0;
                  state                 <= RELEASE;
               end else begin
                  readyCnt <= readyCnt + RCNT_W'(1);
               end
            end
            RELEASE: begin
               if (!reqValid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
